// File: rtl/button_event_gen_pkg.sv
// Shared types for the button event generator: channel FSM states and the
// event-type codes that the game logic uses to tag button actions.
package button_event_gen_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    DOWN   = 2'd1,
    REPEAT = 2'd2
  } chan_state_t;

  typedef enum logic [2:0] {
    EV_NONE    = 3'd0,
    EV_PRESS   = 3'd1,
    EV_RELEASE = 3'd2,
    EV_LONG    = 3'd3,
    EV_REPEAT  = 3'd4
  } event_type_t;

  // At most one pulse is high per channel, so a plain priority encode is exact.
  function automatic event_type_t event_type(input logic press, input logic rel,
                                             input logic long_press, input logic rpt);
    if (press)           return EV_PRESS;
    else if (rel)        return EV_RELEASE;
    else if (long_press) return EV_LONG;
    else if (rpt)        return EV_REPEAT;
    else                 return EV_NONE;
  endfunction

endpackage

// File: rtl/button_event_gen_channel.sv
// Single button channel: IDLE/DOWN/REPEAT FSM with a cycle counter that
// produces registered press, release, long-press and auto-repeat pulses.
//
// state  | meaning
// IDLE   | button up, no events pending
// DOWN   | button held, counting towards the long press
// REPEAT | long press seen, counting between auto-repeat pulses
module button_event_channel
  import button_event_gen_pkg::*;
#(
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_WIDTH     = 25,
  parameter bit ACTIVE_LOW    = 1'b1
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic btn_state,
  output logic press,
  output logic release_evt,
  output logic long_press,
  output logic repeat_evt,
  output logic held
);

  localparam logic [CNT_WIDTH-1:0] LONG_LAST   = CNT_WIDTH'(LONG_CYCLES - 1);
  localparam logic [CNT_WIDTH-1:0] REPEAT_LAST = CNT_WIDTH'(REPEAT_CYCLES - 1);

  chan_state_t          state;
  logic [CNT_WIDTH-1:0] cnt;
  logic                 act;

  assign act = btn_state ^ ACTIVE_LOW;

  always_ff @(posedge clk) begin
    press       <= 1'b0;
    release_evt <= 1'b0;
    long_press  <= 1'b0;
    repeat_evt  <= 1'b0;
    if (reset || !enable) begin
      state <= IDLE;
      cnt   <= '0;
      held  <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (act) begin
            press <= 1'b1;
            held  <= 1'b1;
            cnt   <= '0;
            state <= DOWN;
          end
        end
        DOWN: begin
          // release wins over a long press landing on the same edge
          if (!act) begin
            release_evt <= 1'b1;
            held        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else if (cnt == LONG_LAST) begin
            long_press <= 1'b1;
            cnt        <= '0;
            state      <= REPEAT;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        REPEAT: begin
          if (!act) begin
            release_evt <= 1'b1;
            held        <= 1'b0;
            cnt         <= '0;
            state       <= IDLE;
          end else if (cnt == REPEAT_LAST) begin
            repeat_evt <= 1'b1;
            cnt        <= '0;
          end else begin
            cnt <= cnt + 1'b1;
          end
        end
        default: begin
          state <= IDLE;
          cnt   <= '0;
          held  <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: rtl/button_event_gen.sv
// Turns NUM_BUTTONS debounced button levels into single-cycle press, release,
// long-press and auto-repeat events, one independent channel per button.
module button_event_gen
  import button_event_gen_pkg::*;
#(
  parameter int NUM_BUTTONS   = 4,
  parameter bit ACTIVE_LOW    = 1'b1,
  parameter int LONG_CYCLES   = 25_000_000,
  parameter int REPEAT_CYCLES = 5_000_000,
  parameter int CNT_WIDTH     = 25
) (
  input  logic                   clk,
  input  logic                   reset,
  input  logic                   enable,
  input  logic [NUM_BUTTONS-1:0] btn_state,
  output logic [NUM_BUTTONS-1:0] press,
  output logic [NUM_BUTTONS-1:0] release_evt,
  output logic [NUM_BUTTONS-1:0] long_press,
  output logic [NUM_BUTTONS-1:0] repeat_evt,
  output logic [NUM_BUTTONS-1:0] held
);

  for (genvar i = 0; i < NUM_BUTTONS; i++) begin : g_chan
    button_event_channel #(
      .LONG_CYCLES  (LONG_CYCLES),
      .REPEAT_CYCLES(REPEAT_CYCLES),
      .CNT_WIDTH    (CNT_WIDTH),
      .ACTIVE_LOW   (ACTIVE_LOW)
    ) u_chan (
      .clk        (clk),
      .reset      (reset),
      .enable     (enable),
      .btn_state  (btn_state[i]),
      .press      (press[i]),
      .release_evt(release_evt[i]),
      .long_press (long_press[i]),
      .repeat_evt (repeat_evt[i]),
      .held       (held[i])
    );
  end

endmodule
